// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the EX operand stage and the ALU it feeds.
// ALU op codes, operand-select constants and the hard-wired zero register index.
package ex_operand_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-side, MEM/WB-forwarding and EX-side signal bundle of the operand stage.
// master drives decode/forward sources; slave is the operand stage itself.
interface ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [XLEN-1:0]       id_imm;
  logic [3:0]            id_alu_select;
  logic                  id_asel;
  logic                  id_bsel;
  logic                  id_reg_wen;
  logic                  id_mem_read;
  logic                  stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic                  mem_reg_wen;
  logic [XLEN-1:0]       mem_result;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic                  wb_reg_wen;
  logic [XLEN-1:0]       wb_data;
  logic                  ex_valid;
  logic [3:0]            alu_select;
  logic [XLEN-1:0]       amux_output;
  logic [XLEN-1:0]       bmux_output;
  logic [XLEN-1:0]       ex_store_data;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_wen;
  logic                  ex_mem_read;
  logic                  load_use_hazard;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_imm, id_alu_select, id_asel, id_bsel, id_reg_wen,
           id_mem_read, stall, flush, mem_rd_addr, mem_reg_wen, mem_result,
           wb_rd_addr, wb_reg_wen, wb_data,
    input  ex_valid, alu_select, amux_output, bmux_output, ex_store_data, ex_pc,
           ex_rd_addr, ex_reg_wen, ex_mem_read, load_use_hazard
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_imm, id_alu_select, id_asel, id_bsel, id_reg_wen,
           id_mem_read, stall, flush, mem_rd_addr, mem_reg_wen, mem_result,
           wb_rd_addr, wb_reg_wen, wb_data,
    output ex_valid, alu_select, amux_output, bmux_output, ex_store_data, ex_pc,
           ex_rd_addr, ex_reg_wen, ex_mem_read, load_use_hazard
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand RAW forwarding select: MEM beats WB beats regfile; x0 never forwarded.
// Purely combinational, no backpressure.
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic                  mem_reg_wen,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_reg_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       fwd_data
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  always_comb begin
    fwd_data = rf_data;
    if (rs_addr != X0) begin
      if (mem_reg_wen && (mem_rd_addr == rs_addr)) begin
        fwd_data = mem_result;
      end else if (wb_reg_wen && (wb_rd_addr == rs_addr)) begin
        fwd_data = wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding and load-use bubble insertion; 1-cycle ID->EX.
// Backpressure: stall holds EX, load_use_hazard asks upstream to hold IF/ID, flush kills EX.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                clk,
  input logic                rst,
  ex_operand_stage_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  typedef struct packed {
    logic                  valid;
    logic                  reg_wen;
    logic                  mem_read;
    alu_op_e               alu_select;
    logic                  asel;
    logic                  bsel;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
  } ex_reg_t;

  ex_reg_t         ex_q;
  ex_reg_t         ex_d;
  logic            hazard;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] amux;
  logic [XLEN-1:0] bmux;

  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != X0) && bus.id_valid &&
                  ((ex_q.rd_addr == bus.id_rs1_addr) || (ex_q.rd_addr == bus.id_rs2_addr));

  // A producer may retire through WB while EX is frozen; capture it so it is not lost.
  assign wb_hit_rs1 = bus.wb_reg_wen && (bus.wb_rd_addr != X0) && (bus.wb_rd_addr == ex_q.rs1_addr);
  assign wb_hit_rs2 = bus.wb_reg_wen && (bus.wb_rd_addr != X0) && (bus.wb_rd_addr == ex_q.rs2_addr);

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d.valid    = 1'b0;
      ex_d.reg_wen  = 1'b0;
      ex_d.mem_read = 1'b0;
    end else if (bus.stall) begin
      if (wb_hit_rs1) ex_d.rs1_data = bus.wb_data;
      if (wb_hit_rs2) ex_d.rs2_data = bus.wb_data;
    end else if (hazard) begin
      ex_d.valid    = 1'b0;
      ex_d.reg_wen  = 1'b0;
      ex_d.mem_read = 1'b0;
    end else begin
      ex_d.valid      = bus.id_valid;
      ex_d.reg_wen    = bus.id_valid & bus.id_reg_wen;
      ex_d.mem_read   = bus.id_valid & bus.id_mem_read;
      ex_d.alu_select = alu_op_e'(bus.id_alu_select);
      ex_d.asel       = bus.id_asel;
      ex_d.bsel       = bus.id_bsel;
      ex_d.rs1_addr   = bus.id_rs1_addr;
      ex_d.rs2_addr   = bus.id_rs2_addr;
      ex_d.rd_addr    = bus.id_rd_addr;
      ex_d.pc         = bus.id_pc;
      ex_d.imm        = bus.id_imm;
      ex_d.rs1_data   = bus.id_rs1_data;
      ex_d.rs2_data   = bus.id_rs2_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr     (ex_q.rs1_addr),
    .rf_data     (ex_q.rs1_data),
    .mem_reg_wen (bus.mem_reg_wen),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_result  (bus.mem_result),
    .wb_reg_wen  (bus.wb_reg_wen),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_data     (bus.wb_data),
    .fwd_data    (fwd_rs1)
  );

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr     (ex_q.rs2_addr),
    .rf_data     (ex_q.rs2_data),
    .mem_reg_wen (bus.mem_reg_wen),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_result  (bus.mem_result),
    .wb_reg_wen  (bus.wb_reg_wen),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_data     (bus.wb_data),
    .fwd_data    (fwd_rs2)
  );

  always_comb begin
    amux = fwd_rs1;
    case (ex_q.asel)
      ASEL_RS1: amux = fwd_rs1;
      ASEL_PC:  amux = ex_q.pc;
    endcase
    bmux = fwd_rs2;
    case (ex_q.bsel)
      BSEL_RS2: bmux = fwd_rs2;
      BSEL_IMM: bmux = ex_q.imm;
    endcase
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.alu_select      = ex_q.alu_select;
  assign bus.amux_output     = amux;
  assign bus.bmux_output     = bmux;
  assign bus.ex_store_data   = fwd_rs2;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.ex_rd_addr      = ex_q.rd_addr;
  assign bus.ex_reg_wen      = ex_q.reg_wen;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, load-use bubbles, stall refresh, flush, async reset.
module tb_ex_operand_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_rd_addr = '0; bus.id_imm = '0;
    bus.id_alu_select = '0; bus.id_asel = 1'b0; bus.id_bsel = 1'b0;
    bus.id_reg_wen = 1'b0; bus.id_mem_read = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.mem_rd_addr = '0; bus.mem_reg_wen = 1'b0; bus.mem_result = '0;
    bus.wb_rd_addr = '0; bus.wb_reg_wen = 1'b0; bus.wb_data = '0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic asel, input logic bsel,
                          input logic wen, input logic mrd, input logic [3:0] op);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
    bus.id_rd_addr = rd; bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
    bus.id_asel = asel; bus.id_bsel = bsel; bus.id_reg_wen = wen; bus.id_mem_read = mrd;
    bus.id_alu_select = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #3;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_reg_wen !== 1'b0) begin errors++; $display("FAIL rst_reg_wen: got %b expected 0", bus.ex_reg_wen); end
    checks++; if (bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", bus.ex_mem_read); end
    checks++; if (bus.ex_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.ex_pc); end
    checks++; if (bus.ex_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d expected 0", bus.ex_rd_addr); end
    checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL rst_alu_sel: got %0d expected 0", bus.alu_select); end
    checks++; if (bus.amux_output !== 32'h0) begin errors++; $display("FAIL rst_amux: got %h expected 0", bus.amux_output); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_idle();
    drive_id(32'h100, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    bus.id_valid = 1'b0;
    bus.mem_rd_addr = 5'd5; bus.mem_reg_wen = 1'b1; bus.mem_result = 32'h7;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 32'h100) begin errors++; $display("FAIL b2b_pc: got %h expected 100", bus.ex_pc); end
    checks++; if (bus.ex_rd_addr !== 5'd6) begin errors++; $display("FAIL b2b_rd: got %0d expected 6", bus.ex_rd_addr); end
    checks++; if (bus.ex_reg_wen !== 1'b1) begin errors++; $display("FAIL b2b_wen: got %b expected 1", bus.ex_reg_wen); end
    checks++; if (bus.amux_output !== 32'h7) begin errors++; $display("FAIL b2b_amux_mem: got %h expected 7", bus.amux_output); end
    checks++; if (bus.bmux_output !== 32'h3) begin errors++; $display("FAIL b2b_bmux_imm: got %h expected 3", bus.bmux_output); end
    bus.mem_reg_wen = 1'b0;
    bus.wb_rd_addr = 5'd5; bus.wb_reg_wen = 1'b1; bus.wb_data = 32'h9;
    #1;
    checks++; if (bus.amux_output !== 32'h9) begin errors++; $display("FAIL b2b_amux_wb: got %h expected 9", bus.amux_output); end
  endtask

  task automatic test_mem_priority();
    drive_idle();
    drive_id(32'h180, 5'd1, 5'd3, 5'd7, 32'h1, 32'h99, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    tick();
    bus.mem_rd_addr = 5'd3; bus.mem_reg_wen = 1'b1; bus.mem_result = 32'h11;
    bus.wb_rd_addr = 5'd3; bus.wb_reg_wen = 1'b1; bus.wb_data = 32'h22;
    #1;
    checks++; if (bus.bmux_output !== 32'h11) begin errors++; $display("FAIL prio_bmux: got %h expected 11", bus.bmux_output); end
    checks++; if (bus.ex_store_data !== 32'h11) begin errors++; $display("FAIL prio_store: got %h expected 11", bus.ex_store_data); end
    checks++; if (bus.alu_select !== 4'd1) begin errors++; $display("FAIL prio_alu_sel: got %0d expected 1", bus.alu_select); end
    checks++; if (bus.amux_output !== 32'h1) begin errors++; $display("FAIL prio_amux_rf: got %h expected 1", bus.amux_output); end
    bus.mem_reg_wen = 1'b0;
    #1;
    checks++; if (bus.ex_store_data !== 32'h22) begin errors++; $display("FAIL prio_store_wb: got %h expected 22", bus.ex_store_data); end
    bus.wb_reg_wen = 1'b0;
    #1;
    checks++; if (bus.bmux_output !== 32'h99) begin errors++; $display("FAIL prio_bmux_rf: got %h expected 99", bus.bmux_output); end
  endtask

  task automatic test_x0_guard();
    drive_idle();
    drive_id(32'h1c0, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    bus.mem_rd_addr = 5'd0; bus.mem_reg_wen = 1'b1; bus.mem_result = 32'hDEAD;
    bus.wb_rd_addr = 5'd0; bus.wb_reg_wen = 1'b1; bus.wb_data = 32'hBEEF;
    #1;
    checks++; if (bus.amux_output !== 32'h0) begin errors++; $display("FAIL x0_amux: got %h expected 0", bus.amux_output); end
    checks++; if (bus.ex_store_data !== 32'h0) begin errors++; $display("FAIL x0_store: got %h expected 0", bus.ex_store_data); end
  endtask

  task automatic test_load_use();
    drive_idle();
    drive_id(32'h1f0, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h8, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    checks++; if (bus.ex_mem_read !== 1'b1) begin errors++; $display("FAIL lu_mem_read: got %b expected 1", bus.ex_mem_read); end
    drive_id(32'h200, 5'd4, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checks++; if (bus.load_use_hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard: got %b expected 1", bus.load_use_hazard); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_reg_wen !== 1'b0) begin errors++; $display("FAIL lu_bubble_wen: got %b expected 0", bus.ex_reg_wen); end
    checks++; if (bus.load_use_hazard !== 1'b0) begin errors++; $display("FAIL lu_hazard_clear: got %b expected 0", bus.load_use_hazard); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_reload_valid: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 32'h200) begin errors++; $display("FAIL lu_reload_pc: got %h expected 200", bus.ex_pc); end
    drive_id(32'h210, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    drive_id(32'h220, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checks++; if (bus.load_use_hazard !== 1'b0) begin errors++; $display("FAIL lu_x0_nohazard: got %b expected 0", bus.load_use_hazard); end
  endtask

  task automatic test_stall_refresh();
    drive_idle();
    drive_id(32'h300, 5'd6, 5'd0, 5'd8, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    bus.stall = 1'b1;
    drive_id(32'h400, 5'd1, 5'd1, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    checks++; if (bus.ex_pc !== 32'h300) begin errors++; $display("FAIL stall_hold_pc: got %h expected 300", bus.ex_pc); end
    bus.wb_rd_addr = 5'd6; bus.wb_reg_wen = 1'b1; bus.wb_data = 32'h55;
    tick();
    bus.wb_reg_wen = 1'b0; bus.wb_data = 32'h0;
    tick();
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.amux_output !== 32'h55) begin errors++; $display("FAIL stall_refresh_amux: got %h expected 55", bus.amux_output); end
    checks++; if (bus.ex_pc !== 32'h300) begin errors++; $display("FAIL stall_end_pc: got %h expected 300", bus.ex_pc); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL stall_end_valid: got %b expected 1", bus.ex_valid); end
  endtask

  task automatic test_flush_reset();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_reg_wen !== 1'b0) begin errors++; $display("FAIL flush_wen: got %b expected 0", bus.ex_reg_wen); end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive_id(32'h500, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    tick();
    checks++; if (bus.ex_mem_read !== 1'b1) begin errors++; $display("FAIL pre_rst_mem_read: got %b expected 1", bus.ex_mem_read); end
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_reg_wen !== 1'b0) begin errors++; $display("FAIL arst_wen: got %b expected 0", bus.ex_reg_wen); end
    checks++; if (bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL arst_mem_read: got %b expected 0", bus.ex_mem_read); end
    checks++; if (bus.ex_pc !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h expected 0", bus.ex_pc); end
    checks++; if (bus.ex_rd_addr !== 5'd0) begin errors++; $display("FAIL arst_rd: got %0d expected 0", bus.ex_rd_addr); end
    checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL arst_alu_sel: got %0d expected 0", bus.alu_select); end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_mem_priority();
    test_x0_guard();
    test_load_use();
    test_stall_refresh();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage.
- Sits directly upstream of the ALU. It registers decoded instruction fields and resolves RAW hazards by forwarding from MEM and WB. It then drives alu_select, amux_output and bmux_output to the ALU.
- It also detects load-use hazards and inserts bubbles on stall, flush or hazard.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  regfile read data.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W  register indices.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_select  in  4  ALU op code (same encoding as the ALU).
- id_asel  in  1  0 = rs1, 1 = PC.
- id_bsel  in  1  0 = rs2, 1 = imm.
- id_reg_wen  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- stall  in  1  hold EX contents.
- flush  in  1  kill EX contents (branch/jump redirect).
- mem_rd_addr  in  REG_ADDR_W  MEM-stage destination index.
- mem_reg_wen  in  1  MEM-stage write enable.
- mem_result  in  XLEN  MEM-stage ALU result.
- wb_rd_addr  in  REG_ADDR_W  WB-stage destination index.
- wb_reg_wen  in  1  WB-stage write enable.
- wb_data  in  XLEN  WB-stage write data.
- ex_valid  out  1  EX holds a real instruction.
- alu_select  out  4  to ALU.
- amux_output, bmux_output  out  XLEN  ALU operands.
- ex_store_data  out  XLEN  forwarded rs2, used for stores.
- ex_pc  out  XLEN  registered PC.
- ex_rd_addr  out  REG_ADDR_W  registered rd index.
- ex_reg_wen, ex_mem_read  out  1  registered control, gated by ex_valid.
- load_use_hazard  out  1  combinational; upstream must hold IF/ID while it is high.

Behaviour:
- Reset (async, rst=1):
  - All registers clear to 0, so ex_valid=0, ex_reg_wen=0, ex_mem_read=0, ex_pc=0, ex_rd_addr=0.
  - The ALU select register also clears to 0 (add); alu_select=0 follows combinationally.
  - The operand outputs are combinational and are not guaranteed 0 in reset. Their value follows the forwarding rules below, evaluated on the zeroed registers.
  - Reset asserted mid-operation discards the in-flight instruction. No partial state survives.
- Load-use hazard:
  - load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
- Register update priority, per rising clk:
  1. flush: ex_valid, ex_reg_wen and ex_mem_read are cleared (bubble). Other fields are don't-care. Flush wins over stall and hazard.
  2. stall: all fields hold, except the sticky rs refresh below.
  3. load_use_hazard: load a bubble. The ID instruction is re-presented next cycle by the held upstream.
  4. Otherwise: load all id_* fields. ex_valid = id_valid; ex_reg_wen and ex_mem_read are gated by id_valid.
- Sticky refresh (while stall=1, flush=0):
  - If wb_reg_wen and wb_rd_addr != 0 and it equals the held rs1 (or rs2) index, the stored rs data is overwritten with wb_data.
  - This prevents losing a retiring producer during a multi-cycle stall.
- Forwarding (combinational, per operand, rs1 and rs2 independently):
  - If mem_reg_wen, mem_rd_addr == rs index and the index != 0: select mem_result.
  - Else if wb_reg_wen, wb_rd_addr == rs index and the index != 0: select wb_data.
  - Else: select the registered regfile data.
  - MEM has priority over WB. x0 is never forwarded.
- Operand muxes:
  - amux_output = asel ? ex_pc : fwd_rs1.
  - bmux_output = bsel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always.
- Latency: one cycle from ID inputs to EX outputs. No arithmetic is done here; widths pass through unchanged.

Decomposition:
- Shared package/header:
  - ALU select encodings (ADD=0 … SLTU=9, PASSB=10), also used by the ALU.
  - ASEL_RS1/ASEL_PC and BSEL_RS2/BSEL_IMM constants.
  - REG_X0 = 0.
- One sub-module: fwd_mux (rs index, regfile data and the MEM/WB forward sources in; forwarded data out). It is instantiated twice.

Test Plan:
- Back-to-back dependency: add x5 writes 7 and is in MEM (mem_result=7); EX holds x5 as rs1 with registered data 0, asel=0 -> amux_output=7.
- Double forward, MEM priority: MEM x3=0x11 and WB x3=0x22 both pending; rs2=x3, bsel=0 -> bmux_output=0x11 and ex_store_data=0x11.
- x0 guard: mem_rd_addr=0, mem_reg_wen=1, mem_result=0xDEAD; rs1=x0 with regfile data 0 -> amux_output=0.
- Load-use: EX holds lw x4 (ex_mem_read=1); ID presents rs1=x4 -> load_use_hazard=1, next cycle ex_valid=0; on the following cycle the instruction loads with ex_valid=1.
- Stall refresh: stall held 3 cycles; during the stall, WB writes x6=0x55 and EX rs1=x6 -> after the stall, amux_output=0x55 with no MEM/WB forward active.
- Flush+stall same edge, then async reset: ex_valid=0 and ex_reg_wen=0 after the edge. rst pulsed between clock edges -> all registered outputs go to 0 immediately, without waiting for clk.
